// File: rtl/router_1xn.sv
// 1-to-N packet router: header/payload/parity byte stream steered to per-port FWFT FIFOs.
// Header reaches its FIFO one cycle after acceptance; busy stalls the input while the target FIFO is full.

// Generic FWFT FIFO with synchronous flush; head data reads 0 while empty.
// Zero-latency head; a push while full is ignored, and a push that coincides with a flush is discarded.
module fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] head_dat,
  output logic          vld,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, count;
  logic          empty, do_push, do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == (PW+1)'(DEPTH));
  assign vld      = ~empty;
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty;
  assign head_dat = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end
endmodule

// Router top: FSM parses packets, checks even-XOR parity, drops bad destinations.
// Each port flushes itself after TIMEOUT unread cycles without disturbing the FSM.
module router_1xn #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 3,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DW-1:0]           d_in,
  input  logic                    pkt_vld,
  output logic                    busy,
  output logic                    error,
  input  logic [NUM_PORTS-1:0]    rd_en,
  output logic [NUM_PORTS*DW-1:0] d_out,
  output logic [NUM_PORTS-1:0]    vld_out
);
  localparam int AW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int LW = DW - AW;
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [LW-1:0] len;
    logic [AW-1:0] dest;
  } hdr_t;

  typedef enum logic [2:0] {IDLE, HDR_WR, LOAD, CHECK, DROP} state_t;

  state_t               state, state_nxt;
  hdr_t                 hdr_q, hdr_in;
  logic [DW-1:0]        acc_q, par_q, wr_dat;
  logic [LW-1:0]        bcnt_q;
  logic                 err_q, accept, wr_en, full_sel;
  logic [NUM_PORTS-1:0] full, push;
  logic [2**AW-1:0]     full_pad;

  assign hdr_in = hdr_t'(d_in);
  assign accept = pkt_vld & ~busy;
  assign error  = err_q;

  // Pad so an out-of-range dest never indexes past the vector.
  always_comb begin
    full_pad                = '0;
    full_pad[NUM_PORTS-1:0] = full;
  end
  assign full_sel = full_pad[hdr_q.dest];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_dat    = d_in;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = ({1'b0, hdr_in.dest} >= (AW+1)'(NUM_PORTS)) ? DROP : HDR_WR;
      end
      HDR_WR: begin
        busy   = 1'b1;
        wr_dat = hdr_q;
        if (!full_sel) begin
          wr_en     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy = full_sel;
        if (accept) begin
          wr_en = 1'b1;
          if (bcnt_q == hdr_q.len) state_nxt = CHECK;
        end
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      DROP: begin
        if (accept && bcnt_q == hdr_q.len) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bcnt_q counts payload bytes; reaching len marks the parity byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hdr_q  <= '0;
      acc_q  <= '0;
      par_q  <= '0;
      bcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hdr_q  <= hdr_in;
            acc_q  <= d_in;
            bcnt_q <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (bcnt_q == hdr_q.len) begin
              par_q <= d_in;
            end else begin
              acc_q  <= acc_q ^ d_in;
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        CHECK: err_q <= (acc_q != par_q);
        DROP: begin
          if (accept) begin
            if (bcnt_q == hdr_q.len) err_q <= 1'b1;
            else                     bcnt_q <= bcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [TW-1:0] to_cnt;
    logic          flush;

    assign push[i] = wr_en & (hdr_q.dest == AW'(i));
    assign flush   = vld_out[i] & ~rd_en[i] & (to_cnt == TW'(TIMEOUT-1));

    fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[i]),
      .push_dat (wr_dat),
      .pop      (rd_en[i]),
      .flush    (flush),
      .head_dat (d_out[i*DW +: DW]),
      .vld      (vld_out[i]),
      .full     (full[i])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           to_cnt <= '0;
      else if (!vld_out[i] || rd_en[i] || flush) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn (DW=8, NUM_PORTS=3, DEPTH=16, TIMEOUT=30).
module tb_router_1xn;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d_in = '0;
  logic        pkt_vld = 1'b0;
  logic        busy, error;
  logic [2:0]  rd_en = '0;
  logic [23:0] d_out;
  logic [2:0]  vld_out;

  int checks = 0, errors = 0;
  int err_pulses = 0, busy_hits = 0, v2_cnt = 0;

  router_1xn #(.DW(8), .NUM_PORTS(3), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .pkt_vld(pkt_vld), .busy(busy),
    .error(error), .rd_en(rd_en), .d_out(d_out), .vld_out(vld_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (error === 1'b1)      err_pulses++;
    if (vld_out[2] === 1'b1) v2_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    d_in    = b;
    pkt_vld = 1'b1;
    if (busy) busy_hits++;
    while (busy === 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_byte_wait: busy still %b after %0d cycles, required 0", busy, guard);
    end
    step();
    pkt_vld = 1'b0;
  endtask

  task automatic read_byte(input int p, output logic [7:0] got, output logic v);
    got      = d_out[p*8 +: 8];
    v        = vld_out[p];
    rd_en[p] = 1'b1;
    step();
    rd_en[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, error} !== 2'b00) begin errors++;
      $display("FAIL reset_busy_err: busy,error=%b required 00", {busy, error}); end
    checks++;
    if (vld_out !== 3'b000 || d_out !== 24'h0) begin errors++;
      $display("FAIL reset_outputs: vld_out=%b d_out=%h required 000/000000", vld_out, d_out); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'h0D); send_byte(8'h11); send_byte(8'h22);
    checks++;
    if (vld_out !== 3'b010) begin errors++;
      $display("FAIL midload_vld: vld_out=%b required 010", vld_out); end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, error} !== 2'b00) begin errors++;
      $display("FAIL midrst_busy_err: busy,error=%b required 00", {busy, error}); end
    checks++;
    if (vld_out !== 3'b000 || d_out !== 24'h0) begin errors++;
      $display("FAIL midrst_outputs: vld_out=%b d_out=%h required 000/000000", vld_out, d_out); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_packet();
    logic [7:0] pk [5];
    logic [7:0] got;
    logic v;
    int e0 = err_pulses;
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    for (int i = 0; i < 5; i++) send_byte(pk[i]);
    checks++;
    if (vld_out !== 3'b010) begin errors++;
      $display("FAIL good_vld: vld_out=%b required 010", vld_out); end
    step(); step();
    for (int i = 0; i < 5; i++) begin
      read_byte(1, got, v);
      checks++;
      if (v !== 1'b1 || got !== pk[i]) begin errors++;
        $display("FAIL good_read%0d: vld=%b data=%h required 1/%h", i, v, got, pk[i]); end
    end
    checks++;
    if (vld_out !== 3'b000) begin errors++;
      $display("FAIL good_drained: vld_out=%b required 000", vld_out); end
    checks++;
    if (err_pulses !== e0) begin errors++;
      $display("FAIL good_no_error: error pulses=%0d required 0", err_pulses - e0); end
  endtask

  task automatic test_bad_parity();
    logic [7:0] pk [5];
    logic [7:0] got;
    logic v;
    int e0 = err_pulses;
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(pk[i]);
    checks++;
    if (error !== 1'b0) begin errors++;
      $display("FAIL badpar_in_check: error=%b required 0", error); end
    step();
    checks++;
    if (error !== 1'b1) begin errors++;
      $display("FAIL badpar_pulse: error=%b required 1", error); end
    step();
    checks++;
    if (error !== 1'b0) begin errors++;
      $display("FAIL badpar_pulse_end: error=%b required 0", error); end
    checks++;
    if (err_pulses - e0 !== 1) begin errors++;
      $display("FAIL badpar_count: pulses=%0d required 1", err_pulses - e0); end
    for (int i = 0; i < 5; i++) begin
      read_byte(1, got, v);
      checks++;
      if (v !== 1'b1 || got !== pk[i]) begin errors++;
        $display("FAIL badpar_read%0d: vld=%b data=%h required 1/%h", i, v, got, pk[i]); end
    end
  endtask

  task automatic test_bad_dest();
    int e0 = err_pulses;
    busy_hits = 0;
    send_byte(8'h0B); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h11);
    checks++;
    if (error !== 1'b1) begin errors++;
      $display("FAIL drop_error: error=%b required 1", error); end
    checks++;
    if (busy_hits !== 0 || busy !== 1'b0) begin errors++;
      $display("FAIL drop_busy: busy seen %0d times, busy=%b, required 0/0", busy_hits, busy); end
    step();
    checks++;
    if (error !== 1'b0 || err_pulses - e0 !== 1) begin errors++;
      $display("FAIL drop_pulse: error=%b pulses=%0d required 0/1", error, err_pulses - e0); end
    checks++;
    if (vld_out !== 3'b000) begin errors++;
      $display("FAIL drop_vld: vld_out=%b required 000", vld_out); end
  endtask

  task automatic test_backpressure();
    logic [7:0] s [22];
    logic [7:0] got;
    logic v;
    int rd_idx = 0;
    int e0 = err_pulses;
    s[0]  = 8'h50;
    s[21] = 8'h50;
    for (int i = 1; i <= 20; i++) begin
      s[i]  = 8'(i);
      s[21] = s[21] ^ 8'(i);
    end
    for (int j = 0; j < 16; j++) send_byte(s[j]);
    checks++;
    if (busy !== 1'b1) begin errors++;
      $display("FAIL bp_full_busy: busy=%b required 1", busy); end
    for (int j = 16; j < 22; j++) begin
      d_in    = s[j];
      pkt_vld = 1'b1;
      checks++;
      if (busy !== 1'b1) begin errors++;
        $display("FAIL bp_stall%0d: busy=%b required 1", j, busy); end
      read_byte(0, got, v);
      checks++;
      if (v !== 1'b1 || got !== s[rd_idx]) begin errors++;
        $display("FAIL bp_read%0d: vld=%b data=%h required 1/%h", rd_idx, v, got, s[rd_idx]); end
      rd_idx++;
      checks++;
      if (busy !== 1'b0) begin errors++;
        $display("FAIL bp_admit%0d: busy=%b required 0", j, busy); end
      step();
      pkt_vld = 1'b0;
    end
    while (rd_idx < 22) begin
      read_byte(0, got, v);
      checks++;
      if (v !== 1'b1 || got !== s[rd_idx]) begin errors++;
        $display("FAIL bp_read%0d: vld=%b data=%h required 1/%h", rd_idx, v, got, s[rd_idx]); end
      rd_idx++;
    end
    checks++;
    if (vld_out[0] !== 1'b0 || err_pulses !== e0) begin errors++;
      $display("FAIL bp_end: vld0=%b pulses=%0d required 0/0", vld_out[0], err_pulses - e0); end
  endtask

  task automatic test_timeout();
    logic [7:0] p2 [3];
    logic [7:0] p0 [3];
    logic [7:0] q2 [3];
    logic [7:0] got;
    logic v;
    int g = 0;
    int e0 = err_pulses;
    p2 = '{8'h06, 8'h5A, 8'h5C};
    p0 = '{8'h04, 8'h77, 8'h73};
    q2 = '{8'h06, 8'hA5, 8'hA3};
    v2_cnt = 0;
    for (int i = 0; i < 3; i++) send_byte(p2[i]);
    for (int i = 0; i < 3; i++) send_byte(p0[i]);
    while (vld_out[2] === 1'b1 && g < 100) begin
      step();
      g++;
    end
    checks++;
    if (g >= 100) begin errors++;
      $display("FAIL to_wait: vld_out[2] still high after %0d cycles, required low", g); end
    checks++;
    if (v2_cnt !== 30) begin errors++;
      $display("FAIL to_cycles: vld_out[2] high %0d cycles, required 30", v2_cnt); end
    checks++;
    if (d_out[23:16] !== 8'h00 || vld_out[0] !== 1'b1) begin errors++;
      $display("FAIL to_ports: d_out2=%h vld0=%b required 00/1", d_out[23:16], vld_out[0]); end
    for (int i = 0; i < 3; i++) begin
      read_byte(0, got, v);
      checks++;
      if (v !== 1'b1 || got !== p0[i]) begin errors++;
        $display("FAIL to_port0_read%0d: vld=%b data=%h required 1/%h", i, v, got, p0[i]); end
    end
    for (int i = 0; i < 3; i++) send_byte(q2[i]);
    for (int i = 0; i < 3; i++) begin
      read_byte(2, got, v);
      checks++;
      if (v !== 1'b1 || got !== q2[i]) begin errors++;
        $display("FAIL to_port2_read%0d: vld=%b data=%h required 1/%h", i, v, got, q2[i]); end
    end
    checks++;
    if (vld_out !== 3'b000 || err_pulses !== e0) begin errors++;
      $display("FAIL to_end: vld_out=%b pulses=%0d required 000/0", vld_out, err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_good_packet();
    test_bad_parity();
    test_bad_dest();
    test_backpressure();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
